rsa_modexp_core: RTL and testbench

Toy-width RSA cipher engine. It computes data_out = data_in^X mod N by square-and-multiply, where X is the public exponent E when encrypting and the private exponent D when decrypting. The default key is p=13, q=17, N=221, E=5, D=77. Encryptor and decryptor paths of the crypto subsystem each instantiate one copy; mode selects the exponent.

---
 rtl/rsa_pkg.sv | 12 +
 rtl/rsa_modmul.sv | 17 +
 rtl/rsa_modexp_core.sv | 84 ++++++++
 tb/tb_rsa_modexp_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared constants and encodings for the toy RSA modular exponentiation engine.
package rsa_pkg;
  localparam int RSA_W = 8;
  localparam int RSA_N = 221;
  localparam int RSA_E = 5;
  localparam int RSA_D = 77;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;
endpackage

// File: rtl/rsa_modmul.sv
// Combinational (a*b) mod N. The full 2W-bit product is reduced in one step.
module rsa_modmul #(
  parameter int W = 8,
  parameter int N = 221
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  // One extra bit so that N = 2^W is still representable.
  localparam logic [2*W:0] NM = (2*W+1)'(N);

  logic [2*W-1:0] full;

  assign full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign p    = W'({1'b0, full} % NM);
endmodule

// File: rtl/rsa_modexp_core.sv
// data_out = data_in^(mode ? D : E) mod N, LSB-first square-and-multiply, fixed W-cycle run.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int W = RSA_W,
  parameter int N = RSA_N,
  parameter int E = RSA_E,
  parameter int D = RSA_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int            CW   = $clog2(W + 1);
  localparam logic [W:0]    NW   = (W+1)'(N);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  base, result, expo;
  logic [CW-1:0] cnt;
  logic          err_pend;
  logic [W-1:0]  mul_out, sq_out;

  rsa_modmul #(.W(W), .N(N)) u_mul (.a(result), .b(base), .p(mul_out));
  rsa_modmul #(.W(W), .N(N)) u_sq  (.a(base),   .b(base), .p(sq_out));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      base     <= '0;
      result   <= '0;
      expo     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if ({1'b0, data_in} < NW) begin
            base     <= data_in;
            result   <= W'(1);
            expo     <= (mode == DEC) ? W'(D) : W'(E);
            cnt      <= '0;
            err      <= 1'b0;
            err_pend <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            err_pend <= 1'b1;
            state    <= FIN;
          end
        end
        // All W bits are walked even when the exponent runs out, keeping timing constant.
        RUN: begin
          if (expo[0]) result <= mul_out;
          base <= sq_out;
          expo <= expo >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          data_out <= err_pend ? '0 : result;
          done     <= 1'b1;
          err      <= err_pend;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core with the default key (N=221, E=5, D=77).
module tb_rsa_modexp_core;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       busy, done, err;

  int total = 0;
  int passed = 0;

  rsa_modexp_core dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] din;
    logic [7:0] dout;
    logic       e;
    int         lat;
    int         bsy;
  } vec_t;

  vec_t tv[9];

  function automatic int mexp(int b, int x);
    int r = 1;
    for (int i = 0; i < x; i++) r = (r * b) % 221;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulses start for one edge, then waits (bounded) for done.
  task automatic run_op(input logic m, input logic [7:0] din,
                        output logic [7:0] dout, output logic e, output logic e0,
                        output int lat, output int bcnt, output logic dn2);
    @(negedge clk);
    start = 1'b1; mode = m; data_in = din;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = err;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    dout = data_out;
    e = err;
    @(posedge clk); #1;
    dn2 = done;
  endtask

  initial begin
    logic [7:0] dout, c;
    logic e, e0, dn2, saw;
    int lat, bcnt;
    int dedge[$];
    int dvals[$];

    tv[0] = '{1'b0, 8'd65,  8'd182, 1'b0, 9, 8};
    tv[1] = '{1'b1, 8'd182, 8'd65,  1'b0, 9, 8};
    tv[2] = '{1'b0, 8'd0,   8'd0,   1'b0, 9, 8};
    tv[3] = '{1'b0, 8'd1,   8'd1,   1'b0, 9, 8};
    tv[4] = '{1'b0, 8'd220, 8'd220, 1'b0, 9, 8};
    tv[5] = '{1'b1, 8'd220, 8'd220, 1'b0, 9, 8};
    tv[6] = '{1'b0, 8'd221, 8'd0,   1'b1, 1, 0};
    tv[7] = '{1'b0, 8'd255, 8'd0,   1'b1, 1, 0};
    tv[8] = '{1'b0, 8'd2,   8'd32,  1'b0, 9, 8};

    #1;
    chk("reset data_out", int'(data_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].m, tv[i].din, dout, e, e0, lat, bcnt, dn2);
      chk($sformatf("vec%0d data_out", i), int'(dout), int'(tv[i].dout));
      chk($sformatf("vec%0d err", i), int'(e), int'(tv[i].e));
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d busy cycles", i), bcnt, tv[i].bsy);
      chk($sformatf("vec%0d done pulse width", i), int'(dn2), 0);
    end

    // err holds after completion and is cleared once a legal start is accepted.
    run_op(1'b0, 8'd230, dout, e, e0, lat, bcnt, dn2);
    chk("err path err", int'(e), 1);
    repeat (3) @(posedge clk);
    #1 chk("err held", int'(err), 1);
    run_op(1'b1, 8'd182, dout, e, e0, lat, bcnt, dn2);
    chk("err cleared at accept", int'(e0), 0);
    chk("after err data_out", int'(dout), 65);

    for (int m = 0; m < 221; m++) begin
      run_op(1'b0, 8'(m), c, e, e0, lat, bcnt, dn2);
      chk($sformatf("enc %0d", m), int'(c), mexp(m, 5));
      run_op(1'b1, c, dout, e, e0, lat, bcnt, dn2);
      chk($sformatf("roundtrip %0d", m), int'(dout), m);
    end

    // start held high: one result every 10 cycles; mid-run data_in changes ignored.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; data_in = 8'd65;
    for (int k = 0; k < 31; k++) begin
      @(posedge clk); #1;
      if (k == 3) data_in = 8'd3;
      if (k == 7) data_in = 8'd65;
      if (k == 27) start = 1'b0;
      if (done) begin
        dedge.push_back(k);
        dvals.push_back(int'(data_out));
      end
    end
    chk("held start done count", dedge.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < dedge.size()) begin
        chk($sformatf("held start done edge %0d", k), dedge[k], 9 + 10 * k);
        chk($sformatf("held start data_out %0d", k), dvals[k], 182);
      end
    end

    // Reset during RUN aborts with no done; engine is usable afterwards.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; data_in = 8'd65;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid reset data_out", int'(data_out), 0);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset done", int'(done), 0);
    chk("mid reset err", int'(err), 0);
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    chk("no done after abort", int'(saw), 0);
    run_op(1'b0, 8'd2, dout, e, e0, lat, bcnt, dn2);
    chk("post reset enc 2", int'(dout), 32);
    chk("post reset latency", lat, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
